// File: rtl/inst_fetch_decode.sv
// Instruction fetch over a req/ack memory handshake, with the held word
// split into fields and decoded into the sig_extend control code.
module inst_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        pc_load,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic        fetch_err,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] im,
    output logic [1:0]  SigExtendSignal,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        load_ok;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_ok = pc_load &&
                  ((state_q == IDLE) || (state_q == VALID && !stall));
        if (flush) begin
            state_d = IDLE;
            inst_d  = '0;
            err_d   = 1'b0;
        end else if (load_ok) begin
            // Misaligned targets complete at once without touching memory
            if (pc_in[1:0] == 2'b00) begin
                state_d = REQ;
                addr_d  = pc_in;
            end else begin
                state_d = VALID;
                inst_d  = '0;
                err_d   = 1'b1;
                pc_d    = pc_in;
                cnt_d   = cnt_q + 32'd1;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (imem_ack) begin
                        state_d = VALID;
                        inst_d  = imem_rdata;
                        pc_d    = addr_q;
                        err_d   = 1'b0;
                        cnt_d   = cnt_q + 32'd1;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            inst_q  <= '0;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // 11 makes sig_extend produce zero for formats without an immediate
    always_comb begin
        SigExtendSignal = 2'b11;
        case (inst_q[31:26])
            6'b000100, 6'b000101, 6'b001000, 6'b001001,
            6'b001010, 6'b001011, 6'b100011, 6'b101011:
                SigExtendSignal = 2'b01;
            6'b001100, 6'b001101, 6'b001110:
                SigExtendSignal = 2'b00;
            6'b001111:
                SigExtendSignal = 2'b10;
            default:
                SigExtendSignal = 2'b11;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = addr_q;
    assign inst_valid  = (state_q == VALID);
    assign fetch_err   = err_q;
    assign inst        = inst_q;
    assign pc_out      = pc_q;
    assign fetch_count = cnt_q;
    assign opcode      = inst_q[31:26];
    assign rs          = inst_q[25:21];
    assign rt          = inst_q[20:16];
    assign rd          = inst_q[15:11];
    assign funct       = inst_q[5:0];
    assign im          = inst_q[15:0];

endmodule

// File: doc/inst_fetch_decode.md
# inst_fetch_decode

Fetches one 32-bit instruction per request from instruction memory over a req/ack handshake and holds it in an instruction register. Splits the held instruction into its fields. Drives the immediate and the 2-bit extend-control code consumed directly by the immediate sign-extension stage. Sits between the PC-update unit and sig_extend / register file in the CPU datapath.

## Interface
- RESET_PC, 32'h0000_0000: value of pc_out after reset.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc_in  in  32  address of the next instruction, from the PC-update unit.
- pc_load  in  1  start a fetch at pc_in; accepted only in IDLE or in VALID with stall=0.
- stall  in  1  downstream not ready; holds VALID contents.
- flush  in  1  discard the held or in-flight instruction.
- imem_req  out  1  memory request; held high until ack.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst and the decoded fields are valid.
- fetch_err  out  1  misaligned fetch (pc_in[1:0]≠0); qualified by inst_valid.
- inst  out  32  held instruction.
- pc_out  out  32  address of the held instruction.
- opcode  out  6  inst[31:26]. rs/rt/rd out 5 each: inst[25:21]/[20:16]/[15:11]. funct out 6: inst[5:0].
- im  out  16  inst[15:0]; feeds sig_extend im.
- SigExtendSignal  out  2  feeds sig_extend control.
- fetch_count  out  32  completed fetches, including error fetches.

## Operation
- States: IDLE, REQ, VALID.
- IDLE: imem_req=0, inst_valid=0.
  - pc_load with pc_in[1:0]=0 → REQ. Latch imem_addr=pc_in.
  - pc_load with pc_in[1:0]≠0 → VALID with inst=0, fetch_err=1, pc_out=pc_in. No memory request is issued.
- REQ: imem_req=1, imem_addr held, pc_load ignored.
  - imem_ack=1 → VALID. Latch inst=imem_rdata, pc_out=imem_addr, fetch_err=0, fetch_count+1.
- VALID: inst_valid=1.
  - stall=1 → all outputs held, pc_load ignored.
  - stall=0 and pc_load → behaves as IDLE+pc_load in the same cycle (back-to-back fetch).
  - stall=0 and no pc_load → IDLE.
- flush (any state) has priority over pc_load, ack and stall.
  - Next state IDLE; inst ← 0, fetch_err ← 0, imem_req ← 0.
  - An ack coinciding with flush is discarded and not counted.
  - pc_out and fetch_count are kept.
- SigExtendSignal is a combinational decode of inst[31:26]:
  - 01 (sign): 000100 beq, 000101 bne, 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu, 100011 lw, 101011 sw.
  - 00 (zero): 001100 andi, 001101 ori, 001110 xori.
  - 10 (upper): 001111 lui.
  - 11: all others (R-type, j, jal, unknown, and inst=0), so sig_extend yields zero.
- fetch_count wraps 32'hFFFF_FFFF → 0.
- Reset values:
  - state=IDLE, imem_req=0, imem_addr=0, inst_valid=0, fetch_err=0.
  - inst=0, so opcode/rs/rt/rd/funct/im=0 and SigExtendSignal=11.
  - pc_out=RESET_PC, fetch_count=0.

## Timing
- All state updates occur on the rising edge of clock. Reset is synchronous and active-high and overrides all other inputs, including mid-fetch; an ack in the reset cycle is discarded.
- Latency:
  - pc_load at edge t → imem_req=1 during cycle t+1.
  - ack in the first REQ cycle → inst_valid=1 in cycle t+2 (2-cycle minimum).
  - Each wait cycle (ack=0) adds one cycle.
  - Misaligned fetch: inst_valid one cycle after pc_load.
- imem_addr must not change while imem_req=1 and ack=0.
- Throughput: one instruction per 2 cycles with zero-wait memory and continuous pc_load in VALID.
- Decoded outputs are combinational from registers only: no path from imem_rdata to im or SigExtendSignal.

## Test plan
- Reset, then pc_load with pc_in=0x0000_3000, rdata=0x2008_FFFF (addi) and ack in the first REQ cycle → inst_valid in cycle 2, pc_out=0x3000, im=0xFFFF, SigExtendSignal=01, rt=8, fetch_count=1.
- Fetch 0x3C01_1234 (lui) with 3 wait cycles → imem_req high for 4 cycles with address stable, then SigExtendSignal=10, im=0x1234. Fetch 0x3421_00FF (ori) → SigExtendSignal=00.
- Fetch R-type 0x0122_5020 → SigExtendSignal=11, rs=9, rt=2, rd=10, funct=0x20. Hold stall=1 for 5 cycles with pc_load asserted → outputs unchanged, no new imem_req.
- pc_in=0x0000_3002 → no imem_req, inst_valid=1 next cycle, fetch_err=1, inst=0, fetch_count increments.
- flush asserted in the same cycle as imem_ack during REQ → IDLE, inst_valid=0, inst=0, fetch_count unchanged. Also assert reset mid-REQ → all reset values next cycle.
- Preload fetch_count to 0xFFFF_FFFF via repeated fetches or a forced value, then one more fetch → fetch_count=0.
